// File: rtl/axi_tagctrl_way_sched_pkg.sv
// Shared types for the tag-controller way scheduler: unit indices, the fixed
// unit priority order and the per-way lock state.
package axi_tagctrl_way_sched_pkg;

  localparam int unsigned NumUnits = 4;

  typedef logic [1:0] unit_idx_t;

  typedef enum unit_idx_t {
    EvictUnit = 2'd0,
    RefilUnit = 2'd1,
    WChanUnit = 2'd2,
    RChanUnit = 2'd3
  } unit_e;

  // Entry 0 is the highest priority: Refill > Evict > WChan > RChan.
  localparam unit_idx_t [NumUnits-1:0] UnitPrio = {RChanUnit, WChanUnit, EvictUnit, RefilUnit};

  typedef enum logic {
    LockIdle = 1'b0,
    LockHeld = 1'b1
  } lock_state_e;

  function automatic logic [NumUnits-1:0] unit_onehot(input unit_idx_t u);
    return NumUnits'(1) << u;
  endfunction

endpackage

// File: rtl/axi_tagctrl_way_sched_arb.sv
// Per-way 4:1 arbiter: aging counters with urgent escape, fixed-priority
// select and a lock register that holds a stalled grant until it handshakes.
module axi_tagctrl_way_sched_arb
  import axi_tagctrl_way_sched_pkg::*;
#(
  parameter int unsigned MaxWait  = 15,
  parameter int unsigned CntWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumUnits-1:0] pres_i,
  input  logic [NumUnits-1:0] elig_i,
  input  logic                way_ready_i,
  output logic                valid_o,
  output unit_idx_t           unit_o,
  output logic [NumUnits-1:0] grant_o,
  output logic [NumUnits-1:0] urgent_o,
  output lock_state_e         state_o
);

  localparam logic [CntWidth-1:0] AgeMax = CntWidth'(MaxWait);

  logic [NumUnits-1:0][CntWidth-1:0] age_q, age_d;
  logic [NumUnits-1:0]               hs;
  lock_state_e                       lock_q, lock_d;
  unit_idx_t                         lock_unit_q, lock_unit_d;
  unit_idx_t                         sel;
  logic                              sel_found;
  logic                              lock_hit;

  always_comb begin
    urgent_o = '0;
    for (int u = 0; u < NumUnits; u++) begin
      urgent_o[u] = elig_i[u] && (age_q[u] == AgeMax);
    end
  end

  // Urgent requesters form their own priority class above everyone else.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int p = 0; p < NumUnits; p++) begin
      if (!sel_found && urgent_o[UnitPrio[p]]) begin
        sel       = UnitPrio[p];
        sel_found = 1'b1;
      end
    end
    for (int p = 0; p < NumUnits; p++) begin
      if (!sel_found && elig_i[UnitPrio[p]]) begin
        sel       = UnitPrio[p];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    lock_hit    = (lock_q == LockHeld) && pres_i[lock_unit_q];
    valid_o     = 1'b0;
    unit_o      = '0;
    lock_d      = LockIdle;
    lock_unit_d = lock_unit_q;
    if (lock_hit) begin
      valid_o = 1'b1;
      unit_o  = lock_unit_q;
    end else if (sel_found) begin
      valid_o = 1'b1;
      unit_o  = sel;
    end
    grant_o = valid_o ? unit_onehot(unit_o) : '0;
    hs      = way_ready_i ? grant_o : '0;
    if (valid_o && !way_ready_i) begin
      lock_d      = LockHeld;
      lock_unit_d = unit_o;
    end
  end

  always_comb begin
    for (int u = 0; u < NumUnits; u++) begin
      if (!elig_i[u] || hs[u]) begin
        age_d[u] = '0;
      end else if (age_q[u] == AgeMax) begin
        age_d[u] = AgeMax;
      end else begin
        age_d[u] = age_q[u] + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      age_q       <= '0;
      lock_q      <= LockIdle;
      lock_unit_q <= '0;
    end else begin
      age_q       <= age_d;
      lock_q      <= lock_d;
      lock_unit_q <= lock_unit_d;
    end
  end

  assign state_o = lock_q;

  a_lock_kept: assert property (@(posedge clk_i) disable iff (rst_i)
    (lock_q == LockHeld) |-> pres_i[lock_unit_q])
    else $error("locked request withdrawn before handshake");

endmodule

// File: rtl/axi_tagctrl_way_sched.sv
// Way request scheduler: per-way arbiters, read credit counters, ready fan-in.
// Optional per-unit grant/stall counters under AXI_TAGCTRL_WAY_SCHED_PERF_EN.
//
// Handshake: a unit's request to way w completes in a cycle where req_valid_i
// and req_ready_o are both high; once raised, req_valid_i holds until then.
module axi_tagctrl_way_sched
  import axi_tagctrl_way_sched_pkg::*;
#(
  parameter int unsigned NumWays        = 8,
  parameter int unsigned MaxWait        = 15,
  parameter int unsigned MaxOutstanding = 9,
  parameter int unsigned CntWidth       = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumUnits-1:0]                req_valid_i,
  input  logic [NumUnits-1:0][NumWays-1:0]   req_way_ind_i,
  output logic [NumUnits-1:0]                req_ready_o,
  output logic [NumWays-1:0]                 way_valid_o,
  output unit_idx_t [NumWays-1:0]            way_unit_o,
  input  logic [NumWays-1:0]                 way_ready_i,
  input  logic [1:0]                         rsp_done_i,
  output logic [1:0]                         credit_full_o,
  output logic [NumUnits-1:0]                urgent_o,
  output logic [NumWays-1:0]                 dbg_lock_o
`ifdef AXI_TAGCTRL_WAY_SCHED_PERF_EN
  ,
  output logic [NumUnits-1:0][15:0]          perf_grant_o,
  output logic [NumUnits-1:0][15:0]          perf_stall_o
`endif
);

  localparam int unsigned CredW = $clog2(MaxOutstanding + 1);
  typedef logic [CredW-1:0] cred_t;
  localparam cred_t CredMax = CredW'(MaxOutstanding);

  cred_t [1:0]                       credit_q, credit_d;
  logic  [1:0]                       full_q, full_d;
  logic  [1:0]                       rd_hs;
  logic  [NumUnits-1:0]              blocked;
  logic  [NumWays-1:0][NumUnits-1:0] pres, elig, grant, way_urg;
  logic  [NumWays-1:0]               arb_valid;
  unit_idx_t [NumWays-1:0]           arb_unit;
  lock_state_e                       arb_state [NumWays];
  logic  [NumUnits-1:0]              ready, urg;

  always_comb begin
    blocked            = '0;
    blocked[EvictUnit] = (credit_q[0] == CredMax);
    blocked[RChanUnit] = (credit_q[1] == CredMax);
    for (int w = 0; w < NumWays; w++) begin
      for (int u = 0; u < NumUnits; u++) begin
        pres[w][u] = req_valid_i[u] & req_way_ind_i[u][w];
      end
      elig[w] = pres[w] & ~blocked;
    end
  end

  for (genvar w = 0; w < NumWays; w++) begin : g_way
    axi_tagctrl_way_sched_arb #(
      .MaxWait  (MaxWait),
      .CntWidth (CntWidth)
    ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .pres_i      (pres[w]),
      .elig_i      (elig[w]),
      .way_ready_i (way_ready_i[w]),
      .valid_o     (arb_valid[w]),
      .unit_o      (arb_unit[w]),
      .grant_o     (grant[w]),
      .urgent_o    (way_urg[w]),
      .state_o     (arb_state[w])
    );
  end

  always_comb begin
    ready = '0;
    urg   = '0;
    for (int w = 0; w < NumWays; w++) begin
      ready = ready | (grant[w] & {NumUnits{way_ready_i[w]}});
      urg   = urg | way_urg[w];
      dbg_lock_o[w] = (arb_state[w] == LockHeld);
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign way_valid_o = rst_i ? '0 : arb_valid;
  assign way_unit_o  = rst_i ? '0 : arb_unit;
  assign req_ready_o = rst_i ? '0 : ready;
  assign urgent_o    = rst_i ? '0 : urg;

  assign rd_hs = {ready[RChanUnit], ready[EvictUnit]};

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      credit_d[r] = credit_q[r];
      if (rd_hs[r] && !(rsp_done_i[r] && credit_q[r] != '0)) begin
        credit_d[r] = credit_q[r] + CredW'(1);
      end else if (!rd_hs[r] && rsp_done_i[r] && credit_q[r] != '0) begin
        credit_d[r] = credit_q[r] - CredW'(1);
      end
      full_d[r] = (credit_d[r] == CredMax);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q <= '0;
      full_q   <= '0;
    end else begin
      credit_q <= credit_d;
      full_q   <= full_d;
    end
  end

  assign credit_full_o = full_q;

`ifdef AXI_TAGCTRL_WAY_SCHED_PERF_EN
  logic [NumUnits-1:0][15:0] pg_q, pg_d, ps_q, ps_d;

  always_comb begin
    for (int u = 0; u < NumUnits; u++) begin
      pg_d[u] = pg_q[u] + 16'(ready[u]);
      ps_d[u] = ps_q[u] + 16'(req_valid_i[u] & ~ready[u]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pg_q <= '0;
      ps_q <= '0;
    end else begin
      pg_q <= pg_d;
      ps_q <= ps_d;
    end
  end

  assign perf_grant_o = pg_q;
  assign perf_stall_o = ps_q;
`endif

  for (genvar u = 0; u < NumUnits; u++) begin : g_unit_chk
    a_way_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(req_way_ind_i[u]))
      else $error("way_ind not one-hot");
    // A request with no target way can never be accepted, so it may be withdrawn.
    a_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[u] && (|req_way_ind_i[u]) && !req_ready_o[u]) |=> req_valid_i[u])
      else $error("request withdrawn before ready");
  end

  for (genvar r = 0; r < 2; r++) begin : g_cred_chk
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      rd_hs[r] |-> (credit_q[r] != CredMax))
      else $error("read credit overflow");
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      rsp_done_i[r] |-> (credit_q[r] != '0))
      else $error("response with no read outstanding");
  end

endmodule

// File: tb/tb_axi_tagctrl_way_sched.sv
// Directed bench for axi_tagctrl_way_sched: priority, lock-in, aging escape,
// read credits, asynchronous reset and (when enabled) performance counters.
module tb_axi_tagctrl_way_sched;
  import axi_tagctrl_way_sched_pkg::*;

  localparam int unsigned NumWays = 8;

  logic                            clk_i = 1'b0;
  logic                            rst_i = 1'b1;
  logic [3:0]                      req_valid_i;
  logic [3:0][NumWays-1:0]         req_way_ind_i;
  logic [3:0]                      req_ready_o;
  logic [NumWays-1:0]              way_valid_o;
  logic [NumWays-1:0][1:0]         way_unit_o;
  logic [NumWays-1:0]              way_ready_i;
  logic [1:0]                      rsp_done_i;
  logic [1:0]                      credit_full_o;
  logic [3:0]                      urgent_o;
  logic [NumWays-1:0]              dbg_lock_o;
`ifdef AXI_TAGCTRL_WAY_SCHED_PERF_EN
  logic [3:0][15:0]                perf_grant_o;
  logic [3:0][15:0]                perf_stall_o;
`endif

  int n_vec = 0;
  int n_miscmp = 0;
  logic [1:0] exp_q[$];

  axi_tagctrl_way_sched #(
    .NumWays        (NumWays),
    .MaxWait        (15),
    .MaxOutstanding (9),
    .CntWidth       (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_way_ind_i (req_way_ind_i),
    .req_ready_o   (req_ready_o),
    .way_valid_o   (way_valid_o),
    .way_unit_o    (way_unit_o),
    .way_ready_i   (way_ready_i),
    .rsp_done_i    (rsp_done_i),
    .credit_full_o (credit_full_o),
    .urgent_o      (urgent_o),
    .dbg_lock_o    (dbg_lock_o)
`ifdef AXI_TAGCTRL_WAY_SCHED_PERF_EN
    ,
    .perf_grant_o  (perf_grant_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 ns after the rising edge, checks run at the falling edge
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    req_valid_i   = '0;
    req_way_ind_i = '0;
    way_ready_i   = '1;
    rsp_done_i    = '0;
  endtask

  task automatic set_req(input int u, input int w);
    req_valid_i[u]   = 1'b1;
    req_way_ind_i[u] = NumWays'(1) << w;
  endtask

  task automatic drop_req(input int u);
    req_valid_i[u]   = 1'b0;
    req_way_ind_i[u] = '0;
  endtask

  task automatic return_credits(input int r, input int n);
    rsp_done_i[r] = 1'b1;
    repeat (n) next_cycle();
    rsp_done_i[r] = 1'b0;
  endtask

  initial begin
    clear_inputs();
    // reset state, with a live request that must stay hidden
    set_req(RefilUnit, 0);
    #3;
    check_eq("rst_way_valid", way_valid_o, 0);
    check_eq("rst_req_ready", req_ready_o, 0);
    check_eq("rst_way_unit", way_unit_o, 0);
    check_eq("rst_credit_full", credit_full_o, 0);
    check_eq("rst_urgent", urgent_o, 0);
    clear_inputs();
    repeat (2) next_cycle();
    rst_i = 1'b0;
    next_cycle();

    // 1: Refill beats RChan on way 2, RChan follows next cycle
    set_req(RefilUnit, 2);
    set_req(RChanUnit, 2);
    settle();
    check_eq("t1_way_valid", way_valid_o, 8'b0000_0100);
    check_eq("t1_unit_refill", way_unit_o[2], RefilUnit);
    check_eq("t1_ready_refill", req_ready_o, 4'b0010);
    next_cycle();
    drop_req(RefilUnit);
    settle();
    check_eq("t1_unit_rchan", way_unit_o[2], RChanUnit);
    check_eq("t1_ready_rchan", req_ready_o, 4'b1000);
    next_cycle();
    drop_req(RChanUnit);
    return_credits(1, 1);

    // all-zero way_ind is never granted
    req_valid_i[WChanUnit] = 1'b1;
    settle();
    check_eq("zero_ind_valid", way_valid_o, 0);
    check_eq("zero_ind_ready", req_ready_o, 0);
    next_cycle();
    clear_inputs();

    // 2: stalled Evict on way 0 stays locked while Refill arrives
    exp_q.push_back(EvictUnit);
    exp_q.push_back(RefilUnit);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin set_req(EvictUnit, 0); way_ready_i[0] = 1'b0; end
      if (k == 1) set_req(RefilUnit, 0);
      if (k == 3) way_ready_i[0] = 1'b1;
      if (k == 4) drop_req(EvictUnit);
      settle();
      if (k < 3) begin
        check_eq("t2_unit_held", way_unit_o[0], EvictUnit);
        check_eq("t2_no_ready", req_ready_o, 0);
      end
      if (k == 1) check_eq("t2_locked", dbg_lock_o, 8'b0000_0001);
      if (req_ready_o != 0) begin
        if (exp_q.size() == 0) begin
          check_eq("t2_extra_grant", req_ready_o, 0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check_eq("t2_grant_unit", way_unit_o[0], e);
          check_eq("t2_grant_ready", req_ready_o, 4'(unit_onehot(e)));
        end
      end
      next_cycle();
    end
    check_eq("t2_all_granted", exp_q.size(), 0);
    clear_inputs();
    return_credits(0, 1);

    // 3: RChan starved by streaming Refill on way 1 escapes after 15 waits
    set_req(RefilUnit, 1);
    set_req(RChanUnit, 1);
    for (int k = 0; k < 32; k++) begin
      settle();
      if (k == 0) check_eq("t3_refill_first", way_unit_o[1], RefilUnit);
      if (k == 14) begin
        check_eq("t3_not_urgent", urgent_o, 0);
        check_eq("t3_still_refill", way_unit_o[1], RefilUnit);
      end
      if (k == 15) begin
        check_eq("t3_urgent", urgent_o, 4'b1000);
        check_eq("t3_rchan_unit", way_unit_o[1], RChanUnit);
        check_eq("t3_rchan_ready", req_ready_o, 4'b1000);
      end
      if (k == 16) begin
        check_eq("t3_age_cleared", urgent_o, 0);
        check_eq("t3_refill_again", way_unit_o[1], RefilUnit);
      end
      if (k == 31) check_eq("t3_second_escape", req_ready_o, 4'b1000);
      next_cycle();
    end
    drop_req(RChanUnit);
    settle();
    check_eq("t3_refill_tail", req_ready_o, 4'b0010);
    next_cycle();
    clear_inputs();
    return_credits(1, 2);

    // 4: RChan read credits on way 3
    set_req(RChanUnit, 3);
    for (int k = 0; k < 9; k++) begin
      settle();
      if (k == 0) check_eq("t4_first_grant", req_ready_o, 4'b1000);
      if (k == 8) begin
        check_eq("t4_ninth_grant", req_ready_o, 4'b1000);
        check_eq("t4_not_full_yet", credit_full_o, 0);
      end
      next_cycle();
    end
    settle();
    check_eq("t4_full", credit_full_o, 2'b10);
    check_eq("t4_tenth_blocked", req_ready_o, 0);
    check_eq("t4_way_idle", way_valid_o, 0);
    next_cycle();
    rsp_done_i[1] = 1'b1;
    settle();
    check_eq("t4_still_blocked", req_ready_o, 0);
    next_cycle();
    settle();
    check_eq("t4_reenabled", req_ready_o, 4'b1000);
    check_eq("t4_full_cleared", credit_full_o, 0);
    next_cycle();
    rsp_done_i[1] = 1'b0;
    settle();
    check_eq("t4_simul_kept", req_ready_o, 4'b1000);
    check_eq("t4_simul_notfull", credit_full_o, 0);
    next_cycle();
    rsp_done_i[1] = 1'b1;
    settle();
    check_eq("t4_full_again", credit_full_o, 2'b10);
    check_eq("t4_blocked_again", req_ready_o, 0);
    next_cycle();
    rsp_done_i[1] = 1'b0;
    settle();
    check_eq("t4_last_grant", req_ready_o, 4'b1000);
    next_cycle();
    drop_req(RChanUnit);
    return_credits(1, 9);
    settle();
    check_eq("t4_drained", credit_full_o, 0);
    next_cycle();

    // 5: asynchronous reset while way 4 is locked with Evict credit 5
    set_req(EvictUnit, 4);
    repeat (5) next_cycle();
    way_ready_i[4] = 1'b0;
    next_cycle();
    settle();
    check_eq("t5_locked", dbg_lock_o, 8'b0001_0000);
    rst_i = 1'b1;
    #1;
    check_eq("t5_rst_valid", way_valid_o, 0);
    check_eq("t5_rst_ready", req_ready_o, 0);
    check_eq("t5_rst_unit", way_unit_o, 0);
    check_eq("t5_rst_lock", dbg_lock_o, 0);
    check_eq("t5_rst_full", credit_full_o, 0);
    clear_inputs();
    next_cycle();
    rst_i = 1'b0;
    settle();
    check_eq("t5_idle_after", dbg_lock_o, 0);
    next_cycle();
    set_req(EvictUnit, 4);
    for (int i = 0; i < 9; i++) begin
      settle();
      check_eq("t5_credit_from_zero", req_ready_o, 4'b0001);
      if (i == 8) check_eq("t5_not_full_at8", credit_full_o, 0);
      next_cycle();
    end
    drop_req(EvictUnit);
    settle();
    check_eq("t5_full_at9", credit_full_o, 2'b01);
    next_cycle();
    return_credits(0, 9);

`ifdef AXI_TAGCTRL_WAY_SCHED_PERF_EN
    // 6: Refill on way 5: 2 stall cycles then 4 handshakes
    set_req(RefilUnit, 5);
    way_ready_i[5] = 1'b0;
    repeat (2) next_cycle();
    way_ready_i[5] = 1'b1;
    repeat (4) next_cycle();
    drop_req(RefilUnit);
    settle();
    check_eq("t6_perf_grant", perf_grant_o[RefilUnit], 16'd4);
    check_eq("t6_perf_stall", perf_stall_o[RefilUnit], 16'd2);
    next_cycle();
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
